// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, assembles each instruction from four
// little-endian bytes over a byte-serial handshake, and pulses {pc, inst} to IF/ID.
module if_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          BYTES_PER_INST = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [5:0]  stall,
  input  logic        branch_flag_in,
  input  logic [31:0] branch_target_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_ack_in,
  input  logic [7:0]  mem_byte_in,
  output logic        stall_req_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid_out
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_INST - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        stall_req_q, stall_req_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic        inst_valid_q, inst_valid_d;

  // Only the IF-related stall bits matter here; the rest belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:2];

  // Word as it would look after merging the byte arriving this cycle.
  logic [31:0] word_merged;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_merged[8*gi +: 8] = (byte_cnt_q == 2'(gi)) ? mem_byte_in
                                                             : buf_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    byte_cnt_d   = byte_cnt_q;
    buf_d        = buf_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    pc_out_d     = pc_out_q;
    inst_out_d   = inst_out_q;
    inst_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (branch_flag_in) begin
          pc_d = branch_target_in;
        end else if (!stall[0]) begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          byte_cnt_d = 2'd0;
        end
      end

      S_FETCH: begin
        if (branch_flag_in) begin
          // Dropping the request for a cycle restarts the controller's byte sequence.
          state_d    = S_IDLE;
          pc_d       = branch_target_in;
          byte_cnt_d = 2'd0;
          mem_req_d  = 1'b0;
        end else if (mem_ack_in) begin
          buf_d      = word_merged;
          mem_addr_d = pc_q + {30'b0, byte_cnt_q} + 32'd1;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == LAST_BYTE) begin
            mem_req_d = 1'b0;
            if (!stall[1]) begin
              state_d      = S_IDLE;
              inst_out_d   = word_merged;
              pc_out_d     = pc_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_q + 32'd4;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
      end

      S_HOLD: begin
        if (branch_flag_in) begin
          state_d    = S_IDLE;
          pc_d       = branch_target_in;
          byte_cnt_d = 2'd0;
          mem_req_d  = 1'b0;
        end else if (!stall[1]) begin
          state_d      = S_IDLE;
          inst_out_d   = buf_q;
          pc_out_d     = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + 32'd4;
        end
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    stall_req_d = (state_d == S_FETCH) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      byte_cnt_q   <= 2'd0;
      buf_q        <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'd0;
      stall_req_q  <= 1'b0;
      pc_out_q     <= 32'd0;
      inst_out_q   <= 32'd0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      byte_cnt_q   <= byte_cnt_d;
      buf_q        <= buf_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      stall_req_q  <= stall_req_d;
      pc_out_q     <= pc_out_d;
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign mem_req_out    = mem_req_q;
  assign mem_addr_out   = mem_addr_q;
  assign stall_req_out  = stall_req_q;
  assign pc_out         = pc_out_q;
  assign inst_out       = inst_out_q;
  assign inst_valid_out = inst_valid_q;

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Owns the PC and fetches each 32-bit instruction as four little-endian bytes from the memory controller over a byte-serial handshake.
- Presents {pc, inst} as a one-cycle valid pulse to the IF/ID register, which feeds ID and then the ID/EX register.
- Handles branch redirects from EX and pipeline stalls from the stall controller.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BYTES_PER_INST, 4, bytes per instruction fetch. Fixed at 4; other values are unsupported.

Ports:
clk_in  input  1  clock; all state changes on its rising edge.
rst_in  input  1  reset, synchronous, active-low (0 = reset).
stall  input  6  stall vector; stall[0]=1 freezes PC and inhibits new fetches; stall[1]=1 means IF/ID cannot accept.
branch_flag_in  input  1  redirect request from EX.
branch_target_in  input  32  redirect PC.
mem_req_out  output  1  fetch request to the memory controller.
mem_addr_out  output  32  byte address currently requested.
mem_ack_in  input  1  controller delivers one byte this cycle.
mem_byte_in  input  8  delivered byte.
stall_req_out  output  1  asks the stall controller to hold upstream while a fetch is in flight.
pc_out  output  32  PC of the delivered instruction.
inst_out  output  32  delivered instruction.
inst_valid_out  output  1  one-cycle pulse; pc_out and inst_out are valid.

Behaviour:
- Reset: when rst_in=0 at the clock edge:
  - pc <= RESET_PC; state <= IDLE; byte_cnt <= 0; instruction buffer <= 0.
  - mem_req_out=0, mem_addr_out=0, stall_req_out=0, pc_out=0, inst_out=0, inst_valid_out=0.
  - Reset overrides every other input, including mid-fetch; any partial word is discarded.
- All outputs are registered. stall_req_out=1 exactly while state is FETCH or HOLD.
- Priority each cycle: reset > branch_flag_in > stall > normal operation.
- States:
  - IDLE
    - branch_flag_in=1: pc <= branch_target_in; stay in IDLE.
    - else if stall[0]=0: go to FETCH; mem_req_out <= 1; mem_addr_out <= pc; byte_cnt <= 0.
    - else: hold.
  - FETCH
    - Each cycle with mem_ack_in=1: buf[8*byte_cnt +: 8] <= mem_byte_in; mem_addr_out <= pc + byte_cnt + 1 (mod 2^32); byte_cnt++.
    - Ack with byte_cnt=3 (final byte): mem_req_out <= 0.
      - stall[1]=0: inst_out <= completed word; pc_out <= pc; inst_valid_out <= 1; pc <= pc + 4; go to IDLE.
      - stall[1]=1: go to HOLD.
    - mem_ack_in=0: hold all state; mem_req_out stays 1.
  - HOLD
    - Word is complete and held.
    - When stall[1]=0: emit it as above and go to IDLE.
- inst_valid_out is high for exactly one cycle per emitted instruction and is cleared on every other cycle.
- Branch in FETCH or HOLD:
  - Partial or completed word is discarded; no valid pulse.
  - pc <= branch_target_in; byte_cnt <= 0; mem_req_out <= 0; go to IDLE.
  - mem_req_out is therefore low for at least one cycle, which restarts the controller's byte sequence.
  - A byte acked in the branch cycle is ignored.
- Branch in the same cycle as the final ack: the branch wins; no valid pulse.
- Latency with zero-wait acks and no stalls:
  - Request rises at edge E0; acks are sampled at E1–E4; inst_valid_out is high after E4.
  - The next request rises at E5, giving a 5-cycle-per-instruction throughput.
- PC arithmetic wraps modulo 2^32: PC 32'hFFFF_FFFC fetches bytes at ...FC, ...FD, ...FE, ...FF, then next pc = 0.
- stall[0]=1 while in FETCH does not abort the fetch. It only prevents leaving IDLE.

Test Plan:
- Reset then sequential fetch: rst_in=0 for 2 cycles then 1; RESET_PC=0; controller acks bytes 13,00,50,00 back-to-back.
  - Requested addresses 0,1,2,3.
  - inst_out=32'h0050_0013, pc_out=0, inst_valid_out=1 for one cycle.
  - Next request at address 4.
- Wait states: acks with 2 idle cycles between bytes.
  - mem_req_out stays 1 and mem_addr_out is stable during the gaps.
  - Same word is delivered; valid pulse occurs exactly once.
- Branch mid-fetch: branch_flag_in=1, target=32'h0000_1000 after 2 bytes acked.
  - No valid pulse; mem_req_out=0 for at least 1 cycle.
  - Next request starts at 32'h1000 with byte_cnt=0.
- IF/ID stall: stall[1]=1 during the final ack and held 3 cycles.
  - Enters HOLD with stall_req_out=1; inst_valid_out stays 0.
  - Valid pulse with the correct word the cycle after stall[1] drops.
- Reset mid-fetch and wrap-around:
  - rst_in=0 after 1 byte acked: all outputs return to reset values, pc=RESET_PC.
  - RESET_PC=32'hFFFF_FFFC: addresses FC..FF are requested; the next fetch is at 0.
